// File: rtl/ni_test_core_if.sv
`default_nettype none
// ============================================================================
// Module   : ni_test_core_if
// Brief    : Core-side write port and network-side injection port of the NI
//            transmit buffer.
// Revision : 1.0 - initial release
// ============================================================================
interface ni_test_core_if #(
    parameter int RSIZE = 16
);
    logic [RSIZE-1:0] core_wdata;
    logic [RSIZE-1:0] core_waddr;
    logic             core_wfull;
    logic             ni_wfull;
    logic [RSIZE-1:0] ni_wdata;
    logic [RSIZE-1:0] ni_waddr;

    // Core/router side: drives writes and back-pressure, observes the NI.
    modport master (
        output core_wdata,
        output core_waddr,
        output ni_wfull,
        input  core_wfull,
        input  ni_wdata,
        input  ni_waddr
    );

    // NI buffer side.
    modport slave (
        input  core_wdata,
        input  core_waddr,
        input  ni_wfull,
        output core_wfull,
        output ni_wdata,
        output ni_waddr
    );
endinterface
`default_nettype wire

// File: rtl/ni_test_core.sv
`default_nettype none
// ============================================================================
// Module   : ni_test_core
// Brief    : NI transmit FIFO queueing core (addr,data) writes toward the NoC
//            injection port; address 0 means "no transaction".
// Revision : 1.0 - initial release
// ============================================================================
module ni_test_core #(
    parameter int ADDRSIZE = 5,
    parameter int MSB_SLOT = 5
) (
    input  wire logic         clk,
    input  wire logic         reset,
    ni_test_core_if.slave     bus
);
    localparam int                c_RSIZE      = 1 << (MSB_SLOT - 1);
    localparam int                c_DSIZE      = 1 << MSB_SLOT;
    localparam int                c_DEPTH      = 1 << ADDRSIZE;
    localparam logic [ADDRSIZE:0] c_FULL_COUNT = c_DEPTH[ADDRSIZE:0];

    logic [c_DSIZE-1:0]  r_mem [c_DEPTH];
    logic [ADDRSIZE-1:0] r_wptr;
    logic [ADDRSIZE-1:0] r_rptr;
    logic [ADDRSIZE:0]   r_count;
    logic [c_RSIZE-1:0]  r_ni_waddr;
    logic [c_RSIZE-1:0]  r_ni_wdata;

    logic                w_full;
    logic                w_empty;
    logic                w_pop;
    logic                w_push;
    logic [c_DSIZE-1:0]  w_head;

    assign w_full  = (r_count == c_FULL_COUNT);
    assign w_empty = (r_count == '0);
    assign w_pop   = !bus.ni_wfull && !w_empty;
    // A pop in the same cycle frees the slot, so a push at full is still taken.
    assign w_push  = (bus.core_waddr != '0) && (!w_full || w_pop);
    assign w_head  = r_mem[r_rptr];

    // Storage carries no reset; contents are meaningless until pushed.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {bus.core_waddr, bus.core_wdata};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_ni_waddr <= '0;
            r_ni_wdata <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr     <= r_rptr + 1'b1;
                r_ni_waddr <= w_head[c_DSIZE-1:c_RSIZE];
                r_ni_wdata <= w_head[c_RSIZE-1:0];
            end else begin
                r_ni_waddr <= '0;
                r_ni_wdata <= '0;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign bus.core_wfull = w_full;
    assign bus.ni_waddr   = r_ni_waddr;
    assign bus.ni_wdata   = r_ni_wdata;
endmodule
`default_nettype wire

// File: tb/tb_ni_test_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_ni_test_core
// Brief    : Directed self-checking bench for the NI transmit buffer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ni_test_core;
    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    ni_test_core_if #(.RSIZE(16)) bus ();

    ni_test_core #(
        .ADDRSIZE (5),
        .MSB_SLOT (5)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [15:0] ea, input logic [15:0] ed);
        check({tag, ".addr"}, bus.ni_waddr, ea);
        check({tag, ".data"}, bus.ni_wdata, ed);
    endtask

    task automatic check_full(input string tag, input logic e);
        check({tag, ".wfull"}, {15'b0, bus.core_wfull}, {15'b0, e});
    endtask

    initial begin
        n_tests         = 0;
        n_fail          = 0;
        reset           = 1'b1;
        bus.core_waddr  = 16'h0000;
        bus.core_wdata  = 16'h0000;
        bus.ni_wfull    = 1'b0;

        // Reset
        tick();
        tick();
        check_out("reset", 16'h0000, 16'h0000);
        check_full("reset", 1'b0);
        reset = 1'b0;

        // Single write: visible after the second edge, for one cycle
        bus.core_waddr = 16'hBBBB;
        bus.core_wdata = 16'hAAAA;
        tick();
        bus.core_waddr = 16'h0000;
        bus.core_wdata = 16'h0000;
        check_out("single.lat1", 16'h0000, 16'h0000);
        tick();
        check_out("single.out", 16'hBBBB, 16'hAAAA);
        tick();
        check_out("single.idle", 16'h0000, 16'h0000);

        // Back-to-back pushes under stall
        bus.ni_wfull   = 1'b1;
        bus.core_waddr = 16'hBBBB; bus.core_wdata = 16'hAAAA; tick();
        check_out("stall.0", 16'h0000, 16'h0000);
        bus.core_waddr = 16'hBCCB; bus.core_wdata = 16'hABBA; tick();
        check_out("stall.1", 16'h0000, 16'h0000);
        bus.core_waddr = 16'hBABA; bus.core_wdata = 16'hCCCC; tick();
        check_out("stall.2", 16'h0000, 16'h0000);
        bus.core_waddr = 16'h0000; bus.core_wdata = 16'h0000; tick();
        check_out("stall.3", 16'h0000, 16'h0000);
        bus.ni_wfull = 1'b0;
        tick(); check_out("drain.0", 16'hBBBB, 16'hAAAA);
        tick(); check_out("drain.1", 16'hBCCB, 16'hABBA);
        tick(); check_out("drain.2", 16'hBABA, 16'hCCCC);
        tick(); check_out("drain.idle", 16'h0000, 16'h0000);

        // Fill to 32 entries while stalled
        bus.ni_wfull = 1'b1;
        for (int i = 0; i < 32; i++) begin
            bus.core_waddr = 16'(16'h0100 + i);
            bus.core_wdata = 16'(16'hD000 + i);
            tick();
            check_full("fill", (i == 31));
        end
        bus.core_waddr = 16'hDEAD;
        bus.core_wdata = 16'hBEEF;
        tick();
        check_full("fill.drop", 1'b1);
        bus.core_waddr = 16'h0000;
        bus.core_wdata = 16'h0000;
        bus.ni_wfull   = 1'b0;
        for (int i = 0; i < 32; i++) begin
            tick();
            check_out("fill.drain", 16'(16'h0100 + i), 16'(16'hD000 + i));
            if (i == 0) check_full("fill.first_pop", 1'b0);
        end
        tick();
        check_out("fill.no_dropped", 16'h0000, 16'h0000);

        // 40 pushes while draining: pointers wrap
        for (int i = 0; i < 40; i++) begin
            bus.core_waddr = 16'(16'h2000 + i);
            bus.core_wdata = 16'(16'h3000 + i);
            tick();
            if (i == 0) check_out("wrap.first", 16'h0000, 16'h0000);
            else        check_out("wrap", 16'(16'h2000 + i - 1), 16'(16'h3000 + i - 1));
        end
        bus.core_waddr = 16'h0000;
        bus.core_wdata = 16'h0000;
        tick(); check_out("wrap.last", 16'h2027, 16'h3027);
        tick(); check_out("wrap.idle", 16'h0000, 16'h0000);

        // Full with simultaneous push and pop
        bus.ni_wfull = 1'b1;
        for (int i = 0; i < 32; i++) begin
            bus.core_waddr = 16'(16'h4000 + i);
            bus.core_wdata = 16'(16'h4100 + i);
            tick();
        end
        check_full("pp.full", 1'b1);
        bus.ni_wfull   = 1'b0;
        bus.core_waddr = 16'h1234;
        bus.core_wdata = 16'h5678;
        tick();
        check_out("pp.pop0", 16'h4000, 16'h4100);
        check_full("pp.still_full", 1'b1);
        bus.core_waddr = 16'h0000;
        bus.core_wdata = 16'h0000;
        tick();
        check_full("pp.after_pop", 1'b0);
        check_out("pp.pop1", 16'h4001, 16'h4101);
        for (int i = 2; i < 32; i++) begin
            tick();
            check_out("pp.pop", 16'(16'h4000 + i), 16'(16'h4100 + i));
        end
        tick(); check_out("pp.new", 16'h1234, 16'h5678);
        tick(); check_out("pp.idle", 16'h0000, 16'h0000);

        // Mid-operation asynchronous reset with entries queued
        bus.ni_wfull = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.core_waddr = 16'(16'h5000 + i);
            bus.core_wdata = 16'(16'h5100 + i);
            tick();
        end
        bus.core_waddr = 16'h0000;
        bus.core_wdata = 16'h0000;
        bus.ni_wfull   = 1'b0;
        tick();
        check_out("rst.pre", 16'h5000, 16'h5100);
        #2;
        reset = 1'b1;
        #1;
        check_out("rst.async", 16'h0000, 16'h0000);
        check_full("rst.async", 1'b0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_out("rst.flushed", 16'h0000, 16'h0000);
        end
        bus.core_waddr = 16'h6000;
        bus.core_wdata = 16'h6100;
        tick();
        bus.core_waddr = 16'h0000;
        bus.core_wdata = 16'h0000;
        tick();
        check_out("rst.fresh", 16'h6000, 16'h6100);
        tick();
        check_out("rst.fresh_idle", 16'h0000, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
